// File: rtl/iq_deserializer.sv
// iq_deserializer
// ---------------
// Receive-side counterpart of the I/Q serializer. Samples a one-bit serial
// stream (one bit per clk), hunts for the 32-bit frame sync pattern
// 1,0,I[DATA_W-1:0],0,1,Q[DATA_W-1:0], confirms it over LOCK_FRAMES frames,
// then recovers I/Q sample pairs and tracks sync health while locked.
//
// Ports
//   clk        in   single clock, rising edge
//   rst        in   synchronous active-high reset
//   serial_in  in   serial frame bit, MSB first (complemented line if INVERT)
//   I, Q       out  last recovered samples (two's complement), held between frames
//   iq_valid   out  one-cycle pulse when I/Q update
//   locked     out  high while in LOCKED state
//   sync_err   out  one-cycle pulse on a bad frame while locked
//   err_count  out  saturating count of bad frames seen while locked
module iq_deserializer #(
   parameter int DATA_W      = 14,
   parameter int LOCK_FRAMES = 2,
   parameter int UNLOCK_ERRS = 3,
   parameter int INVERT      = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              serial_in,
   output logic [DATA_W-1:0] I,
   output logic [DATA_W-1:0] Q,
   output logic              iq_valid,
   output logic              locked,
   output logic              sync_err,
   output logic [15:0]       err_count
);

   localparam int FRAME_W = 2 * (DATA_W + 2);
   localparam int BC_W    = $clog2(FRAME_W);
   localparam int GC_W    = $clog2(LOCK_FRAMES + 1);
   localparam int BD_W    = $clog2(UNLOCK_ERRS + 1);
   localparam logic [BC_W-1:0] BC_LAST = BC_W'(FRAME_W - 1);

   typedef enum logic [1:0] {HUNT, CONFIRM, LOCKED} state_t;

   state_t                   state;
   // The oldest bit of the window is never needed after this cycle, so only
   // FRAME_W-1 history bits are stored; the window is history plus the new bit.
   logic [FRAME_W-2:0]       sh;
   logic [BC_W-1:0]          bc;
   logic [GC_W-1:0]          good_cnt;
   logic [BD_W-1:0]          bad_cnt;

   logic                     bit_in;
   logic [FRAME_W-1:0]       win;
   logic                     good;
   logic                     boundary;
   logic signed [DATA_W-1:0] i_smp;
   logic signed [DATA_W-1:0] q_smp;

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   assign bit_in   = (INVERT != 0) ? ~serial_in : serial_in;
   assign win      = {sh, bit_in};
   assign good     = (win[FRAME_W-1 -: 2] == 2'b10) && (win[DATA_W+1 -: 2] == 2'b01);
   assign boundary = (bc == BC_LAST);
   assign i_smp    = win[FRAME_W-3 -: DATA_W];
   assign q_smp    = win[DATA_W-1:0];

   // Window -> registered outputs; all decisions use the window that
   // includes the bit on serial_in this cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= HUNT;
         sh        <= '0;
         bc        <= '0;
         good_cnt  <= '0;
         bad_cnt   <= '0;
         I         <= '0;
         Q         <= '0;
         iq_valid  <= 1'b0;
         locked    <= 1'b0;
         sync_err  <= 1'b0;
         err_count <= '0;
      end else begin
         sh       <= win[FRAME_W-2:0];
         bc       <= boundary ? '0 : bc + 1'b1;
         iq_valid <= 1'b0;
         sync_err <= 1'b0;

         case (state)
            HUNT: begin
               // Bit counter is free-running here; a match realigns it so the
               // next frame's last bit lands on bc == FRAME_W-1.
               if (good) begin
                  bc <= '0;
                  if (LOCK_FRAMES <= 1) begin
                     state    <= LOCKED;
                     locked   <= 1'b1;
                     I        <= i_smp;
                     Q        <= q_smp;
                     iq_valid <= 1'b1;
                     bad_cnt  <= '0;
                  end else begin
                     state    <= CONFIRM;
                     good_cnt <= GC_W'(1);
                  end
               end
            end

            CONFIRM: begin
               if (boundary) begin
                  if (!good) begin
                     state <= HUNT;
                  end else if (int'(good_cnt) + 1 >= LOCK_FRAMES) begin
                     state    <= LOCKED;
                     locked   <= 1'b1;
                     I        <= i_smp;
                     Q        <= q_smp;
                     iq_valid <= 1'b1;
                     bad_cnt  <= '0;
                  end else begin
                     good_cnt <= good_cnt + 1'b1;
                  end
               end
            end

            LOCKED: begin
               if (boundary) begin
                  if (good) begin
                     I        <= i_smp;
                     Q        <= q_smp;
                     iq_valid <= 1'b1;
                     bad_cnt  <= '0;
                  end else begin
                     sync_err  <= 1'b1;
                     err_count <= sat_inc16(err_count);
                     if (int'(bad_cnt) + 1 >= UNLOCK_ERRS) begin
                        state   <= HUNT;
                        locked  <= 1'b0;
                        bad_cnt <= '0;
                     end else begin
                        bad_cnt <= bad_cnt + 1'b1;
                     end
                  end
               end
            end

            default: state <= HUNT;
         endcase
      end
   end

endmodule

// File: doc/iq_deserializer.md
# iq_deserializer

Receive-side counterpart of the modulator's I/Q serializer. It samples a single-bit serial I/Q stream, one bit per `clk` cycle, and hunts for the 32-bit frame sync pattern. Once locked, it recovers 14-bit I/Q sample pairs and reports sync health. It sits on the shared 64 MHz PLL clock and serves as the loopback checker for the transmit path, and as the front end for future receive-side blocks.

## Interface
Parameters:
- `DATA_W`, 14: bits per I or Q sample; frame length `FRAME_W = 2*(DATA_W+2)` (32).
- `LOCK_FRAMES`, 2: consecutive sync-valid frames required to declare lock (≥1).
- `UNLOCK_ERRS`, 3: consecutive bad frames while locked that force loss of lock (≥1).
- `INVERT`, 1: 1 means the input is the complemented line (`serial_N` polarity); the bit is inverted before use.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `serial_in`  in  1  serial frame bit, MSB first, one bit per cycle, synchronous to `clk`.
- `I`  out  `DATA_W`  last recovered I sample, two's complement, held between frames.
- `Q`  out  `DATA_W`  last recovered Q sample, held between frames.
- `iq_valid`  out  1  one-cycle pulse when `I`/`Q` update.
- `locked`  out  1  high while in LOCKED state.
- `sync_err`  out  1  one-cycle pulse on a bad frame while locked.
- `err_count`  out  16  bad-frame count while locked; saturates at 0xFFFF.

## Operation
- Frame bit order on the line (after optional inversion): `1,0,I[13..0],0,1,Q[13..0]`.
  - I_SYNC = 2'b10 and Q_SYNC = 2'b01.
  - 32 bits with no gaps; frames are back-to-back or separated by idle.
- Shift register `sh[FRAME_W-1:0]`. Every cycle: `sh <= {sh[FRAME_W-2:0], bit}`.
- Define `win = {sh[FRAME_W-2:0], bit}`. `win` is "good" when `win[31:30]==2'b10 && win[15:14]==2'b01`.
- Bit counter `bc` runs 0..FRAME_W-1 and wraps. A frame boundary is the cycle where `bc==FRAME_W-1`.
- States:
  - HUNT: `bc` is ignored. If `win` is good, go to CONFIRM with `bc<=0` and `good_cnt<=1`. If `LOCK_FRAMES==1`, go directly to LOCKED and emit that frame.
  - CONFIRM: at each boundary, a good `win` increments `good_cnt`. When `good_cnt` would reach `LOCK_FRAMES`, go to LOCKED and emit the frame. A bad `win` returns to HUNT, and hunting resumes on the next cycle. CONFIRM emits no `iq_valid` and no `sync_err`.
  - LOCKED: at each boundary, a good `win` does three things: sets `I<=win[29:16]` and `Q<=win[13:0]`, pulses `iq_valid`, and clears `bad_cnt`. A bad `win` does three things: pulses `sync_err`, increments `err_count` (saturating), and increments `bad_cnt`. On a bad frame `I`/`Q` hold and no `iq_valid` is issued. When `bad_cnt` reaches `UNLOCK_ERRS`, go to HUNT and drop `locked`.
- Idle line (all zeros after inversion) never matches the sync pattern. While locked, an idle line counts as bad frames.
- `err_count` is cleared only by `rst`. It is not cleared on relock.

## Timing
- Reset values: `I=0`, `Q=0`, `iq_valid=0`, `locked=0`, `sync_err=0`, `err_count=0`. State is HUNT, with `sh`, `bc`, `good_cnt` and `bad_cnt` all 0.
- All outputs are registered. If the last bit of a frame is on `serial_in` in cycle n, then `iq_valid`, `sync_err`, `locked` transitions and the new `I`/`Q` are visible in cycle n+1.
- Continuous traffic while locked gives `iq_valid` exactly every 32 cycles.
- Lock entry: `locked` rises in the same cycle as the `iq_valid` for the locking frame.
- Loss of lock: `sync_err` and the fall of `locked` occur in the same cycle.
- `rst` asserted mid-frame or mid-lock forces all reset values at the next edge. Pulses in flight are dropped.
- `rst` has priority over every other event.

## Test plan
- Reset: hold `rst` 4 cycles with random `serial_in` → all outputs 0. Release, drive 200 zero bits → `locked=0`, no `iq_valid`, no `sync_err`.
- Acquisition: 7 idle bits, then 3 frames of I=0x2A5A, Q=0x15A5 (`INVERT=1`, line driven complemented) → `locked` and `iq_valid` rise 1 cycle after the last bit of frame 2 with I=0x2A5A, Q=0x15A5. Next `iq_valid` comes exactly 32 cycles later.
- False sync: in HUNT, drive one frame whose data mimics sync, followed by misaligned data → CONFIRM fails at the first boundary, state returns to HUNT, `locked` stays 0. A following pair of correct frames then locks.
- Single error: while locked, flip I_SYNC in one frame → one `sync_err` pulse, `err_count=1`, no `iq_valid`, I/Q hold, `locked` stays 1. The next good frame gives `iq_valid` with new data.
- Loss of lock: 3 consecutive bad frames → `sync_err` on each, `err_count=3`, `locked` falls on the 3rd boundary. Two good frames afterward relock, and `err_count` remains 3.
- Reset mid-frame while locked at bit 17 → next cycle all outputs 0. Then one full good frame (`LOCK_FRAMES=2`) produces no `iq_valid`, and relock follows the second frame.
